// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned sequential multiplier: one 4x4 carry-save array multiplier is
// time-shared over four nibble steps, with a valid/ready handshake on each side.

module Carry_Save_Adder_Multiplier4bits (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  logic [3:0][4:0] w_s;  // row sums; bit 4 is a permanent zero feeding the top column
  logic [3:0][3:0] w_c;  // row carries, each one weight above its sum position
  logic [3:0]      w_hi;

  always_comb begin
    w_s = '0;
    w_c = '0;
    for (int j = 0; j < 4; j++) begin
      w_s[0][j] = i_a[j] & i_b[0];
    end
    for (int i = 1; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic x, y, z;
        x = i_a[j] & i_b[i];
        y = w_s[i-1][j+1];
        z = w_c[i-1][j];
        w_s[i][j] = x ^ y ^ z;
        w_c[i][j] = (x & y) | (x & z) | (y & z);
      end
    end
  end

  // Final carry-propagate stage merges the last sum row with its carries.
  assign w_hi = {1'b0, w_s[3][3:1]} + w_c[3];
  assign o_p  = {w_hi, w_s[3][0], w_s[2][0], w_s[1][0], w_s[0][0]};

endmodule

module mul8_seq_ctrl #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic [1:0]  r_step;

  logic        w_accept;
  logic        w_skip;
  logic [3:0]  w_mul_a;
  logic [3:0]  w_mul_b;
  logic [7:0]  w_partial;
  logic [15:0] w_term;

  assign w_accept = in_valid && (r_state == StIdle);
  assign w_skip   = (ZERO_SKIP != 0) && ((a == 8'd0) || (b == 8'd0));

  // step[0] selects the high multiplicand nibble, step[1] the high multiplier nibble
  assign w_mul_a = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_mul_b = r_step[1] ? r_b[7:4] : r_b[3:0];

  Carry_Save_Adder_Multiplier4bits u_mul4 (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_partial)
  );

  always_comb begin
    w_term = '0;
    unique case (r_step)
      2'd0:    w_term = {8'd0, w_partial};
      2'd1,
      2'd2:    w_term = {4'd0, w_partial, 4'd0};
      2'd3:    w_term = {w_partial, 8'd0};
      default: w_term = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_state_d = w_skip ? StDone : StMul;
        end
      end
      StMul: begin
        if (r_step == 2'd3) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StMul:   ;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= '0;
      r_step <= '0;
    end else if (r_state == StMul) begin
      r_acc  <= r_acc + w_term;
      r_step <= r_step + 2'd1;
    end
  end

  // Accumulator doubles as the output register so the result persists into IDLE.
  assign product = r_acc;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(product)));

  a_ready_busy_excl: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && busy));

endmodule

// File: doc/mul8_seq_ctrl.md
MUL8_SEQ_CTRL -- requirements
Module: mul8_seq_ctrl

Interface
REQ-001 Parameter: ZERO_SKIP, default 1, meaning 1 = operand-zero shortcut enabled, 0 = every operation runs the full 4-step sequence.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: in_valid  input  1  operand pair a/b valid.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  8  unsigned multiplicand.
REQ-007 Port: b  input  8  unsigned multiplier.
REQ-008 Port: out_valid  output  1  product valid.
REQ-009 Port: out_ready  input  1  consumer accepts product.
REQ-010 Port: product  output  16  unsigned result a*b.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 Block SHALL instantiate exactly one Carry_Save_Adder_Multiplier4bits (4x4 unsigned, 8-bit product) and compute the 8x8 product by time-sharing it over 4 steps.
REQ-013 States SHALL be IDLE, MUL, DONE; one-hot or binary encoding is an implementation choice.
REQ-014 in_ready SHALL be 1 only in IDLE; acceptance = in_valid & in_ready at a rising edge (cycle 0).
REQ-015 On acceptance the block SHALL register a and b into internal operand registers, clear the 16-bit accumulator and the 2-bit step counter, and enter MUL.
REQ-016 In MUL, step k SHALL drive the 4x4 multiplier with nibbles: k=0 A[3:0]xB[3:0] shift 0; k=1 A[7:4]xB[3:0] shift 4; k=2 A[3:0]xB[7:4] shift 4; k=3 A[7:4]xB[7:4] shift 8.
REQ-017 Each MUL cycle SHALL add (partial << shift) into the 16-bit accumulator; accumulation SHALL be modulo 2^16 (never overflows for 8x8 operands).
REQ-018 Multiplier inputs SHALL come only from the registered operands and the step counter, never directly from a/b.
REQ-019 After step 3 the block SHALL enter DONE; MUL occupies cycles 1-4 and out_valid SHALL first be 1 in cycle 5.
REQ-020 With ZERO_SKIP=1 and registered a==0 or b==0 at acceptance, the block SHALL go directly to DONE with product 0; out_valid is 1 in cycle 1.
REQ-021 In DONE, out_valid SHALL be 1 and product SHALL hold stable until out_valid & out_ready at a rising edge, after which the state SHALL be IDLE in the next cycle.
REQ-022 product SHALL equal the accumulator and SHALL stay unchanged in IDLE until the next DONE.
REQ-023 in_valid asserted outside IDLE SHALL be ignored, with no operand capture.
REQ-024 Minimum issue interval SHALL be 6 cycles (accept, 4 MUL, DONE-handshake); a new acceptance is possible in the cycle after the DONE handshake.
REQ-025 Because the 4x4 multiplier carries gate delays, the clock period SHALL exceed the multiplier plus 16-bit adder settle time; benches SHALL use a period of at least 200 time units.

Reset
REQ-026 When rst=1 at a rising edge: state=IDLE, step counter=0, accumulator=0, operand registers=0, product=0, out_valid=0, busy=0, in_ready=1 in the following cycle.
REQ-027 Reset SHALL take priority over every handshake, including mid-MUL and DONE-awaiting-out_ready; the in-flight operation is discarded with no out_valid.
REQ-028 in_valid during the reset cycle SHALL NOT be accepted.

Verification
REQ-029 a=0x12, b=0x34, out_ready=1 -> out_valid in cycle 5, product=0x03A8, in_ready back to 1 in cycle 6.
REQ-030 a=0xFF, b=0xFF -> product=0xFE01; a=0x80, b=0x02 -> product=0x0100 (cross-nibble carry).
REQ-031 ZERO_SKIP=1, a=0x00, b=0x5A -> out_valid in cycle 1, product=0x0000; same with ZERO_SKIP=0 -> out_valid in cycle 5, product=0x0000.
REQ-032 a=0x0F, b=0xF0, out_ready held 0 for 3 cycles after out_valid -> product=0x0E10 stable, in_ready=0, new in_valid with a=0x11 ignored; handshake on 4th cycle -> IDLE next cycle.
REQ-033 rst=1 at cycle 2 of MUL (a=0xAB, b=0xCD) -> out_valid never asserts, product=0, in_ready=1 next cycle; a following 0xAB*0xCD -> 0x88EF.
REQ-034 Random sweep of 1000 operand pairs with random out_ready stalls -> every product equals a*b, no accepted operand lost or duplicated.
